// File: rtl/avl_bus_pkg.sv
// rtl/avl_bus_pkg.sv - shared constants, state type and round-robin pick for avl_bus_arb
package avl_bus_pkg;

    localparam int ARB_RR      = 0;
    localparam int ARB_FIXED   = 1;
    localparam int MAX_MASTERS = 32;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Rotate the request vector so bit 0 is the pointer, take the lowest set
    // bit, then map back to an absolute index. A zero pointer gives fixed priority.
    function automatic logic [4:0] rr_pick(input logic [31:0] req, input int n, input logic [4:0] ptr);
        logic [31:0] mask;
        logic [63:0] dbl;
        logic [31:0] rot;
        logic [4:0]  k;
        int          sum;
        mask = (n >= MAX_MASTERS) ? '1 : ((32'd1 << n) - 32'd1);
        dbl  = {32'b0, req & mask};
        dbl  = dbl | (dbl << n);
        rot  = 32'(dbl >> ptr) & mask;
        k    = '0;
        for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
            if (rot[i]) k = 5'(i);
        end
        sum = int'(k) + int'(ptr);
        if (sum >= n) sum = sum - n;
        return 5'(sum);
    endfunction

endpackage

// File: rtl/avl_sel_fifo.sv
// rtl/avl_sel_fifo.sv - register FIFO holding the owner index of each outstanding read
module avl_sel_fifo #(
    parameter int  WIDTH = 3,
    parameter int  DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
            else if (do_pop && !do_push) cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/avl_bus_arb.sv
// rtl/avl_bus_arb.sv - N-to-1 Avalon-MM master arbiter with read-return routing
module avl_bus_arb
    import avl_bus_pkg::*;
#(
    parameter int  MASTER_NUM     = 8,
    parameter int  ARB_METHOD     = ARB_RR,
    parameter int  SEL_FIFO_DEPTH = 2,
    localparam int IDX_W          = $clog2(MASTER_NUM),
    localparam int CNT_W          = $clog2(SEL_FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic [MASTER_NUM-1:0] m_read,
    input  logic [MASTER_NUM-1:0] m_write,
    output logic [MASTER_NUM-1:0] m_waitrequest,
    output logic [MASTER_NUM-1:0] m_readdatavalid,
    output logic                  bus_read,
    output logic                  bus_write,
    input  logic                  bus_waitrequest,
    input  logic                  bus_readdatavalid,
    output logic [MASTER_NUM-1:0] grant,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  grant_valid,
    output logic [CNT_W-1:0]      sel_fifo_cnt,
    output logic                  rsp_err
);

    arb_state_e            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [MASTER_NUM-1:0] req;
    logic [31:0]           req_ext;
    logic [IDX_W-1:0]      winner;
    logic [IDX_W-1:0]      head;
    logic                  own_read;
    logic                  own_write;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  sel_full;

    assign req       = m_read | m_write;
    assign own_read  = (state == OWN) & m_read[grant_idx];
    assign own_write = (state == OWN) & m_write[grant_idx];
    assign pop       = bus_readdatavalid & ~fifo_empty;
    assign sel_full  = fifo_full & ~pop;

    // Write wins when the owner asserts both; a full FIFO holds reads back.
    assign bus_write = own_write;
    assign bus_read  = own_read & ~own_write & ~sel_full;
    assign accept    = (bus_read | bus_write) & ~bus_waitrequest;
    assign push      = accept & bus_read;

    assign m_readdatavalid = pop ? (MASTER_NUM'(1) << head) : '0;

    always_comb begin
        m_waitrequest = '1;
        if (state == OWN) m_waitrequest[grant_idx] = ~accept;
    end

    always_comb begin
        req_ext                 = '0;
        req_ext[MASTER_NUM-1:0] = req;
        winner = IDX_W'(rr_pick(req_ext, MASTER_NUM,
                                (ARB_METHOD == ARB_FIXED) ? 5'd0 : 5'(rr_ptr)));
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            rr_ptr      <= '0;
            rsp_err     <= 1'b0;
        end else begin
            if (bus_readdatavalid && fifo_empty) rsp_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant       <= MASTER_NUM'(1) << winner;
                        grant_idx   <= winner;
                        grant_valid <= 1'b1;
                        state       <= OWN;
                    end
                end
                OWN: begin
                    if (accept) begin
                        rr_ptr      <= (grant_idx == IDX_W'(MASTER_NUM - 1)) ? '0 : grant_idx + IDX_W'(1);
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end else if (!m_read[grant_idx] && !m_write[grant_idx]) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    avl_sel_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (SEL_FIFO_DEPTH)
    ) u_sel_fifo (
        .clk   (clk),
        .rst   (rest),
        .push  (push),
        .pop   (pop),
        .din   (grant_idx),
        .head  (head),
        .cnt   (sel_fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_avl_bus_arb.sv
// tb/tb_avl_bus_arb.sv - scoreboard bench for avl_bus_arb with a behavioural reference model
module tb_avl_bus_arb;

    localparam int N = 8;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rest;
    logic [N-1:0] mr, mw;
    logic         bwait, brdv;

    logic [N-1:0] m_waitrequest, m_readdatavalid, grant;
    logic         bus_read, bus_write, grant_valid, rsp_err;
    logic [2:0]   grant_idx;
    logic [1:0]   sel_fifo_cnt;

    logic [N-1:0] fx_wait, fx_rdv, fx_grant;
    logic         fx_br, fx_bw, fx_gv, fx_err;
    logic [2:0]   fx_gidx;
    logic [1:0]   fx_cnt;

    int           checks = 0;
    int           errors = 0;
    int           owner = -1;
    int           ptr = 0;
    int           mcnt = 0;
    logic         exp_err = 1'b0;
    logic         fx_check = 1'b0;
    int           grant_q[$];
    int           rd_q[$];
    int           gcount[N];
    logic [N-1:0] hold;
    logic [N-1:0] last_acc;

    always #5 clk = ~clk;

    avl_bus_arb #(.MASTER_NUM(N), .ARB_METHOD(0), .SEL_FIFO_DEPTH(D)) dut (
        .clk(clk), .rest(rest), .m_read(mr), .m_write(mw),
        .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
        .bus_read(bus_read), .bus_write(bus_write),
        .bus_waitrequest(bwait), .bus_readdatavalid(brdv),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid),
        .sel_fifo_cnt(sel_fifo_cnt), .rsp_err(rsp_err)
    );

    avl_bus_arb #(.MASTER_NUM(N), .ARB_METHOD(1), .SEL_FIFO_DEPTH(D)) dut_fx (
        .clk(clk), .rest(rest), .m_read(mr), .m_write(mw),
        .m_waitrequest(fx_wait), .m_readdatavalid(fx_rdv),
        .bus_read(fx_br), .bus_write(fx_bw),
        .bus_waitrequest(bwait), .bus_readdatavalid(brdv),
        .grant(fx_grant), .grant_idx(fx_gidx), .grant_valid(fx_gv),
        .sel_fifo_cnt(fx_cnt), .rsp_err(fx_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: spec rules evaluated once per cycle on settled inputs.
    initial begin
        logic [N-1:0] req, ewait;
        logic         ebr, ebw, acc, pop, full;
        logic [2:0]   o, j;
        forever begin
            @(negedge clk);
            if (rest) begin
                owner = -1; ptr = 0; mcnt = 0; exp_err = 1'b0;
                grant_q.delete(); rd_q.delete();
                chk("rst_waitrequest", m_waitrequest, {N{1'b1}});
                chk("rst_bus_cmd", {bus_read, bus_write}, 0);
                chk("rst_readdatavalid", m_readdatavalid, 0);
            end else begin
                req = mr | mw;
                pop = brdv && (mcnt > 0);
                ebr = 1'b0; ebw = 1'b0; acc = 1'b0; full = 1'b0;
                ewait = '1;
                o = 3'(owner);
                if (owner >= 0) begin
                    full = (mcnt == D) && !pop;
                    ebw  = mw[o];
                    ebr  = mr[o] && !mw[o] && !full;
                    acc  = (ebr || ebw) && !bwait;
                    ewait[o] = !acc;
                end
                chk("bus_read", bus_read, ebr);
                chk("bus_write", bus_write, ebw);
                chk("m_waitrequest", m_waitrequest, ewait);
                chk("grant_valid", grant_valid, owner >= 0);
                chk("sel_fifo_cnt", sel_fifo_cnt, mcnt);
                chk("rsp_err", rsp_err, exp_err);
                if (brdv && mcnt == 0) begin
                    chk("stray_no_strobe", m_readdatavalid, 0);
                    exp_err = 1'b1;
                end
                if (fx_check && fx_gv) chk("fixed_prio_grant", fx_grant, 8'h01);
                if (owner >= 0) begin
                    if (acc) begin
                        if (ebr) begin
                            rd_q.push_back(owner);
                            mcnt++;
                        end
                        ptr   = (owner + 1) % N;
                        owner = -1;
                    end else if (!mr[o] && !mw[o]) begin
                        owner = -1;
                    end
                end else if (req != 0) begin
                    for (int k = 0; k < N; k++) begin
                        j = 3'((ptr + k) % N);
                        if (req[j]) begin
                            owner = int'(j);
                            break;
                        end
                    end
                    grant_q.push_back(owner);
                end
                if (pop) mcnt--;
            end
        end
    end

    // Monitor: pops expected grants and read-return routes as the DUT shows them.
    initial begin
        logic gv_prev;
        int   e;
        gv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rest) begin
                gv_prev = 1'b0;
            end else begin
                if (grant_valid && !gv_prev) begin
                    if (grant_q.size() == 0) begin
                        chk("grant_unexpected", grant, 0);
                    end else begin
                        e = grant_q.pop_front();
                        if (fx_check) gcount[e]++;
                        chk("grant", grant, 32'(1) << e);
                        chk("grant_idx", grant_idx, e);
                    end
                end
                if (m_readdatavalid != 0) begin
                    if (rd_q.size() == 0) begin
                        chk("rdv_unexpected", m_readdatavalid, 0);
                    end else begin
                        e = rd_q.pop_front();
                        chk("rdv_route", m_readdatavalid, 32'(1) << e);
                    end
                end
                gv_prev = grant_valid;
            end
        end
    end

    task automatic post_neg();
        last_acc = ~m_waitrequest & (mr | mw);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (last_acc[i] && !hold[i]) begin
                mr[i] = 1'b0;
                mw[i] = 1'b0;
            end
        end
        brdv = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        post_neg();
    endtask

    task automatic wait_acc(input int i);
        int n;
        n = 0;
        last_acc = '0;
        while (!last_acc[i] && n < 30) begin
            tick();
            n++;
        end
        chk("accept_seen", last_acc[i], 1);
    endtask

    initial begin
        int n;
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rest = 1'b1; mr = '0; mw = '0; hold = '0; bwait = 1'b0; brdv = 1'b0;
        for (int i = 0; i < N; i++) gcount[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_cnt", sel_fifo_cnt, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(posedge clk);
        #1;
        rest = 1'b0;

        // Single master read and its return beat.
        mr[3] = 1'b1;
        wait_acc(3);
        repeat (2) tick();
        brdv = 1'b1;
        tick();
        repeat (2) tick();

        // Three masters hold writes: RR rotation, fixed-priority instance always master 0.
        hold[0] = 1'b1; hold[2] = 1'b1; hold[5] = 1'b1;
        mw[0] = 1'b1; mw[2] = 1'b1; mw[5] = 1'b1;
        fx_check = 1'b1;
        repeat (30) tick();
        fx_check = 1'b0;
        chk("rr_no_starve_0", gcount[0] >= 4, 1);
        chk("rr_no_starve_2", gcount[2] >= 4, 1);
        chk("rr_no_starve_5", gcount[5] >= 4, 1);
        hold = '0; mw = '0;
        repeat (3) tick();

        // FIFO full: third reader stalls until a return beat frees a slot.
        mr[1] = 1'b1; wait_acc(1);
        mr[4] = 1'b1; wait_acc(4);
        mr[6] = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("full_stall_bus_read", bus_read, 0);
        chk("full_stall_wait6", m_waitrequest[6], 1);
        post_neg();
        brdv = 1'b1;
        @(negedge clk);
        chk("pushpop_bus_read", bus_read, 1);
        chk("pushpop_strobe", m_readdatavalid, 8'h02);
        post_neg();
        tick();
        brdv = 1'b1; tick();
        brdv = 1'b1; tick();
        repeat (2) tick();

        // Return ordering 7 then 0.
        mr[7] = 1'b1; wait_acc(7);
        mr[0] = 1'b1; wait_acc(0);
        brdv = 1'b1; tick();
        brdv = 1'b1; tick();
        repeat (2) tick();

        // Stray return beat with empty FIFO.
        brdv = 1'b1; tick();
        repeat (2) tick();

        // Owner drops its request while stalled.
        bwait = 1'b1;
        mr[2] = 1'b1;
        repeat (3) tick();
        mr[2] = 1'b0;
        repeat (2) tick();
        bwait = 1'b0;
        repeat (2) tick();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(mr[i] | mw[i])) begin
                    if ($urandom_range(0, 3) == 0) begin
                        if ($urandom_range(0, 1) == 1) mr[i] = 1'b1;
                        else mw[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    mr[i] = 1'b0;
                    mw[i] = 1'b0;
                end
            end
            bwait = ($urandom_range(0, 3) == 0);
            brdv  = (mcnt > 0) && ($urandom_range(0, 2) == 0);
            tick();
        end
        mr = '0; mw = '0; bwait = 1'b0;
        n = 0;
        while (mcnt > 0 && n < 20) begin
            brdv = 1'b1;
            tick();
            n++;
        end
        repeat (3) tick();

        // Async reset while owning with one read outstanding.
        mr[5] = 1'b1; wait_acc(5);
        bwait = 1'b1;
        mw[3] = 1'b1;
        tick(); tick();
        chk("pre_reset_owned", grant_valid, 1);
        chk("pre_reset_cnt", sel_fifo_cnt, 1);
        #2;
        rest = 1'b1;
        #1;
        chk("async_grant", grant, 0);
        chk("async_grant_idx", grant_idx, 0);
        chk("async_grant_valid", grant_valid, 0);
        chk("async_cnt", sel_fifo_cnt, 0);
        chk("async_rsp_err", rsp_err, 0);
        chk("async_waitrequest", m_waitrequest, {N{1'b1}});
        chk("async_bus_cmd", {bus_read, bus_write}, 0);
        chk("async_rdv", m_readdatavalid, 0);
        mw = '0;
        mw[0] = 1'b1; mw[6] = 1'b1;
        bwait = 1'b0;
        tick(); tick();
        rest = 1'b0;
        tick();
        @(negedge clk);
        chk("post_reset_first_grant", grant, 8'h01);
        post_neg();
        repeat (4) tick();
        mw = '0;
        repeat (5) tick();

        chk("grant_q_drained", grant_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avl_bus_arb.md
Name: avl_bus_arb

Overview:
- Standalone N-to-1 arbiter/sequencer for the Avalon-MM master side of the bus fabric.
- Selects one requesting master per transfer and gates that master's command onto the shared bus.
- Records the winner index of every accepted read in a selection FIFO so that returning readdatavalid beats route back to the correct master.
- Sits between the master ports and the shared command/response mux. It holds only control state; data and address muxing stay outside.

Parameters:
- MASTER_NUM, 8, number of requesting masters (2..32).
- ARB_METHOD, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SEL_FIFO_DEPTH, 2, maximum outstanding reads (1..16).
- IDX_W, $clog2(MASTER_NUM), localparam, width of a master index.

Ports:
- clk  in  1  clock.
- rest  in  1  asynchronous, active-high reset.
- m_read  in  MASTER_NUM  per-master read request.
- m_write  in  MASTER_NUM  per-master write request.
- m_waitrequest  out  MASTER_NUM  per-master stall.
- m_readdatavalid  out  MASTER_NUM  one-hot routed read-data strobe.
- bus_read  out  1  read command to the shared bus.
- bus_write  out  1  write command to the shared bus.
- bus_waitrequest  in  1  shared-bus stall.
- bus_readdatavalid  in  1  shared-bus read-data strobe.
- grant  out  MASTER_NUM  one-hot current owner; drives the external address/data mux.
- grant_idx  out  IDX_W  binary index of the owner.
- grant_valid  out  1  an owner is selected.
- sel_fifo_cnt  out  $clog2(SEL_FIFO_DEPTH+1)  outstanding reads.
- rsp_err  out  1  sticky: readdatavalid arrived with an empty FIFO.

Behaviour:
- Reset (rest=1, async): state IDLE; grant=0; grant_idx=0; grant_valid=0; RR pointer=0; FIFO empty; rsp_err=0.
- Combinational outputs during reset: m_waitrequest all 1; bus_read=bus_write=0; m_readdatavalid=0.
- State IDLE:
  - req[i] = m_read[i] | m_write[i].
  - If any req is set, choose the winner:
    - RR: first set bit at or above the pointer, wrapping modulo MASTER_NUM.
    - Fixed: lowest set index.
  - Register the winner into grant/grant_idx, set grant_valid, go to OWN. Grant is therefore visible 1 cycle after the request.
- State OWN:
  - bus_read = m_read[grant_idx] & ~sel_full.
  - bus_write = m_write[grant_idx]. If both are asserted, write has priority and bus_read=0.
  - Accept when bus_read or bus_write is 1 and bus_waitrequest=0.
  - m_waitrequest[grant_idx] = ~accept. All other masters see m_waitrequest=1.
  - On accept:
    - If the transfer was a read, push grant_idx into the FIFO.
    - RR pointer <= grant_idx+1 (wrap).
    - Clear grant and grant_valid; return to IDLE.
  - One transfer per grant; minimum 2 cycles per transfer; back-to-back from different masters alternates IDLE/OWN.
  - If the owner drops both requests without being accepted: release to IDLE next cycle with no push and no pointer move.
  - Owner read while the FIFO is full: bus_read=0 and the owner stalls in OWN until a pop frees a slot.
- Response path:
  - When bus_readdatavalid=1 and the FIFO is non-empty: m_readdatavalid[head]=1 in the same cycle (combinational), then pop.
  - When bus_readdatavalid=1 and the FIFO is empty: no strobe to any master; rsp_err <= 1 (sticky until reset).
  - Push and pop in the same cycle: count unchanged, legal even when full (a pop frees the slot the push uses).
  - sel_full = (count == SEL_FIFO_DEPTH) & ~pop.
- Widths: pointer and FIFO indices wrap modulo their range. No arithmetic overflow is permitted.

Decomposition:
- Package avl_bus_pkg:
  - ARB_RR=0, ARB_FIXED=1 constants.
  - typedef enum {IDLE, OWN} arb_state_e.
  - Function for the round-robin pick: rotate, priority-encode, un-rotate.
- Sub-module avl_sel_fifo:
  - Parameterised width/depth register FIFO.
  - Outputs head, cnt, full, empty.
  - Async reset to empty.

Test Plan:
- Single master (m_read[3]=1, waitrequest=0, MASTER_NUM=8) -> grant=8'h08 on cycle 1; bus_read pulses 1 cycle; cnt=1; later readdatavalid -> m_readdatavalid=8'h08; cnt=0.
- RR fairness: masters 0, 2, 5 hold writes continuously (ARB_METHOD=0) -> grant order 0, 2, 5, 0, 2, 5; no starvation over 30 cycles. Same stimulus with ARB_METHOD=1 -> master 0 wins every grant.
- FIFO full (depth 2): three reads from masters 1, 4, 6 with no response -> third owner stalls with bus_read=0. One readdatavalid -> strobe 8'h02, and the master-6 read is accepted in the same or next cycle.
- Response ordering: reads accepted from 7 then 0 -> two readdatavalid beats give 8'h80 then 8'h01. Simultaneous push/pop while cnt=2 -> cnt stays 2.
- Stray readdatavalid with an empty FIFO -> m_readdatavalid=0 and rsp_err=1 sticky. Owner deasserts request mid-waitrequest -> returns to IDLE with no push.
- Assert rest while in OWN with cnt=1 -> all outputs at reset values immediately (async). After deassertion, master 0 wins first (pointer=0).
